seq_alu: RTL and testbench

- Parametrised, multi-cycle successor to the datapath ALU. Single-cycle ops return next cycle; MUL (radix-4 bit-pair Booth) and DIV (non-restoring) iterate.
- Sits between the Y register / BusMuxOut and the Z register (Zhi/Zlo).
- Accepts an encoded opcode with a start/busy/done handshake, so the control unit stalls on busy instead of relying on fixed timing.

---
 rtl/seq_alu_pkg.sv | 37 +++
 rtl/seq_alu_if.sv | 28 ++
 rtl/booth_radix4_step.sv | 27 ++
 rtl/seq_alu.sv | 193 +++++++++++++++++++
 tb/tb_seq_alu.sv | 291 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/seq_alu_pkg.sv
// seq_alu_pkg: shared definitions for the sequential ALU.
//   - Opcode encodings as seen on the op bus.
//   - FSM state encodings (plain 2-bit constants so older control logic
//     can decode them directly).
//   - Helper returning the shift/rotate amount width for a given operand width.
package seq_alu_pkg;

    localparam int OP_AND     = 0;
    localparam int OP_OR      = 1;
    localparam int OP_NEG     = 2;
    localparam int OP_NOT     = 3;
    localparam int OP_ADD     = 4;
    localparam int OP_SUB     = 5;
    localparam int OP_MUL     = 6;
    localparam int OP_DIV     = 7;
    localparam int OP_SHR     = 8;
    localparam int OP_SHRA    = 9;
    localparam int OP_SHL     = 10;
    localparam int OP_ROR     = 11;
    localparam int OP_ROL     = 12;
    localparam int OP_INCPC   = 13;
    localparam int OP_BRANCH  = 14;
    localparam int OP_ILLEGAL = 15;  // this code and anything above is undefined

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE    = 2'd0;
    localparam state_t ST_MUL_RUN = 2'd1;
    localparam state_t ST_DIV_RUN = 2'd2;
    localparam state_t ST_DIV_FIX = 2'd3;

    // Number of low b bits that form a shift/rotate amount.
    function automatic int shamt_w(input int width);
        return $clog2(width);
    endfunction

endpackage

// File: rtl/seq_alu_if.sv
// seq_alu_if: operand/result bus between the control unit and seq_alu.
//   start, op, a, b           : issued by the control unit (master)
//   busy, done, c, div_zero,
//   illegal                   : returned by the ALU (slave)
interface seq_alu_if #(
    parameter int WIDTH = 32,
    parameter int OPW   = 4
);
    logic                 start;
    logic [OPW-1:0]       op;
    logic [WIDTH-1:0]     a;
    logic [WIDTH-1:0]     b;
    logic                 busy;
    logic                 done;
    logic [2*WIDTH-1:0]   c;
    logic                 div_zero;
    logic                 illegal;

    modport master (
        output start, op, a, b,
        input  busy, done, c, div_zero, illegal
    );

    modport slave (
        input  start, op, a, b,
        output busy, done, c, div_zero, illegal
    );
endinterface

// File: rtl/booth_radix4_step.sv
// booth_radix4_step: radix-4 (bit-pair) Booth partial-product select.
//   m   : signed multiplicand
//   win : multiplier window {b[2i+1], b[2i], b[2i-1]}
//   pp  : selected partial product 0, +m, +2m, -m or -2m, two bits wider
//         than m so that -2*MIN is representable.
module booth_radix4_step #(
    parameter int WIDTH = 32
) (
    input  logic signed [WIDTH-1:0] m,
    input  logic        [2:0]       win,
    output logic signed [WIDTH+1:0] pp
);
    logic signed [WIDTH+1:0] m_ext;

    assign m_ext = {{2{m[WIDTH-1]}}, m};

    always_comb begin
        pp = '0;
        case (win)
            3'b001, 3'b010: pp = m_ext;
            3'b011:         pp = m_ext <<< 1;
            3'b100:         pp = -(m_ext <<< 1);
            3'b101, 3'b110: pp = -m_ext;
            default:        pp = '0;
        endcase
    end
endmodule

// File: rtl/seq_alu.sv
// seq_alu: multi-cycle ALU between Y/BusMuxOut and Zhi/Zlo.
//   clock : rising-edge clock
//   clear : synchronous active-low reset
//   bus   : seq_alu_if slave -- start/op/a/b in, busy/done/c/div_zero/illegal out
// Single-cycle ops (and DIV by zero / illegal codes) complete on the edge that
// accepts start. MUL runs WIDTH/2 radix-4 Booth steps; DIV runs WIDTH
// non-restoring iterations on magnitudes followed by one fix-up cycle.
module seq_alu
    import seq_alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int OPW   = 4
) (
    input  logic        clock,
    input  logic        clear,
    seq_alu_if.slave    bus
);
    localparam int SHW = shamt_w(WIDTH);
    localparam int CW  = $clog2(WIDTH);

    // control
    state_t               state;
    logic [CW-1:0]        cnt;
    logic                 busy_r, done_r, div_zero_r, illegal_r;
    logic [2*WIDTH-1:0]   c_r;

    // datapath
    logic signed [WIDTH-1:0] mcand;
    logic signed [WIDTH+2:0] acc;      // running high part of the Booth product
    logic        [WIDTH-1:0] lo;       // multiplier, shifted out as product bits shift in
    logic                    prev;     // b[2i-1] for the next Booth window
    logic        [WIDTH-1:0] dq;       // dividend magnitude, becomes the quotient
    logic        [WIDTH-1:0] dd;       // divisor magnitude
    logic signed [WIDTH+1:0] rem;      // partial remainder, may go negative
    logic                    q_neg, r_neg;

    logic                    accept;
    logic [WIDTH-1:0]        alu_lo;
    logic                    is_ill;
    logic [SHW-1:0]          amt;
    logic [2*WIDTH-1:0]      aa;
    logic [WIDTH-1:0]        abs_a, abs_b;

    logic signed [WIDTH+1:0] pp;
    logic signed [WIDTH+2:0] mul_sum, mul_nxt;
    logic signed [WIDTH+1:0] rem_sh, rem_nx, dd_ext;
    logic        [WIDTH-1:0] r_mag, rem_out, quot;

    assign accept = (state == ST_IDLE) && bus.start;
    assign amt    = bus.b[SHW-1:0];
    assign aa     = {bus.a, bus.a};
    assign is_ill = (bus.op >= OPW'(OP_ILLEGAL));
    assign abs_a  = bus.a[WIDTH-1] ? -bus.a : bus.a;
    assign abs_b  = bus.b[WIDTH-1] ? -bus.b : bus.b;

    always_comb begin
        alu_lo = '0;
        case (bus.op)
            OPW'(OP_AND):    alu_lo = bus.a & bus.b;
            OPW'(OP_OR):     alu_lo = bus.a | bus.b;
            OPW'(OP_NEG):    alu_lo = -bus.a;
            OPW'(OP_NOT):    alu_lo = ~bus.a;
            OPW'(OP_ADD):    alu_lo = bus.a + bus.b;
            OPW'(OP_SUB):    alu_lo = bus.a - bus.b;
            OPW'(OP_MUL):    alu_lo = '0;
            OPW'(OP_DIV):    alu_lo = '0;
            OPW'(OP_SHR):    alu_lo = bus.a >> amt;
            OPW'(OP_SHRA):   alu_lo = $signed(bus.a) >>> amt;
            OPW'(OP_SHL):    alu_lo = bus.a << amt;
            // Rotations shift the doubled operand so the wrapped bits fall in.
            OPW'(OP_ROR):    alu_lo = WIDTH'(aa >> amt);
            OPW'(OP_ROL):    alu_lo = WIDTH'((aa << amt) >> WIDTH);
            OPW'(OP_INCPC):  alu_lo = bus.b + WIDTH'(1);
            OPW'(OP_BRANCH): alu_lo = bus.a + bus.b;
            default:         alu_lo = '0;
        endcase
    end

    booth_radix4_step #(.WIDTH(WIDTH)) u_booth (
        .m   (mcand),
        .win ({lo[1], lo[0], prev}),
        .pp  (pp)
    );

    // Booth step: add the selected multiple, then drop two settled bits into lo.
    assign mul_sum = acc + {pp[WIDTH+1], pp};
    assign mul_nxt = mul_sum >>> 2;

    // Non-restoring step: the quotient bit is 1 when the new remainder is >= 0,
    // which gives the same bits as restoring division.
    assign dd_ext  = {2'b00, dd};
    assign rem_sh  = {rem[WIDTH:0], dq[WIDTH-1]};
    assign rem_nx  = rem[WIDTH+1] ? (rem_sh + dd_ext) : (rem_sh - dd_ext);

    // Fix-up: a negative final remainder gets one divisor added back, then
    // remainder takes the dividend's sign and the quotient the sign product.
    assign r_mag   = rem[WIDTH+1] ? (rem[WIDTH-1:0] + dd) : rem[WIDTH-1:0];
    assign rem_out = r_neg ? -r_mag : r_mag;
    assign quot    = q_neg ? -dq : dq;

    always_ff @(posedge clock) begin
        if (accept) begin
            mcand <= bus.a;
            acc   <= '0;
            lo    <= bus.b;
            prev  <= 1'b0;
            dq    <= abs_a;
            dd    <= abs_b;
            rem   <= '0;
            q_neg <= bus.a[WIDTH-1] ^ bus.b[WIDTH-1];
            r_neg <= bus.a[WIDTH-1];
        end else if (state == ST_MUL_RUN) begin
            acc   <= mul_nxt;
            lo    <= {mul_sum[1:0], lo[WIDTH-1:2]};
            prev  <= lo[1];
        end else if (state == ST_DIV_RUN) begin
            rem   <= rem_nx;
            dq    <= {dq[WIDTH-2:0], ~rem_nx[WIDTH+1]};
        end
    end

    always_ff @(posedge clock) begin
        if (!clear) begin
            state      <= ST_IDLE;
            cnt        <= '0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            c_r        <= '0;
            div_zero_r <= 1'b0;
            illegal_r  <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (bus.start) begin
                        cnt <= '0;
                        if (bus.op == OPW'(OP_MUL)) begin
                            state  <= ST_MUL_RUN;
                            busy_r <= 1'b1;
                        end else if (bus.op == OPW'(OP_DIV) && bus.b != '0) begin
                            state  <= ST_DIV_RUN;
                            busy_r <= 1'b1;
                        end else if (bus.op == OPW'(OP_DIV)) begin
                            c_r        <= {bus.a, {WIDTH{1'b1}}};
                            div_zero_r <= 1'b1;
                            illegal_r  <= 1'b0;
                            done_r     <= 1'b1;
                        end else begin
                            c_r        <= {{WIDTH{1'b0}}, alu_lo};
                            div_zero_r <= 1'b0;
                            illegal_r  <= is_ill;
                            done_r     <= 1'b1;
                        end
                    end
                end
                ST_MUL_RUN: begin
                    cnt <= cnt + CW'(1);
                    if (cnt == CW'(WIDTH/2 - 1)) begin
                        // last pair: the product is taken straight from this step
                        c_r        <= {mul_nxt[WIDTH-1:0], mul_sum[1:0], lo[WIDTH-1:2]};
                        div_zero_r <= 1'b0;
                        illegal_r  <= 1'b0;
                        done_r     <= 1'b1;
                        busy_r     <= 1'b0;
                        state      <= ST_IDLE;
                    end
                end
                ST_DIV_RUN: begin
                    cnt <= cnt + CW'(1);
                    if (cnt == CW'(WIDTH - 1)) begin
                        state <= ST_DIV_FIX;
                    end
                end
                ST_DIV_FIX: begin
                    c_r        <= {rem_out, quot};
                    div_zero_r <= 1'b0;
                    illegal_r  <= 1'b0;
                    done_r     <= 1'b1;
                    busy_r     <= 1'b0;
                    state      <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bus.busy     = busy_r;
    assign bus.done     = done_r;
    assign bus.c        = c_r;
    assign bus.div_zero = div_zero_r;
    assign bus.illegal  = illegal_r;

endmodule

// File: tb/tb_seq_alu.sv
// tb_seq_alu: randomized and directed bench for seq_alu at WIDTH=32.
// Expected results come from a plain-arithmetic model (64-bit products and
// quotients, loop-based rotates) queued at issue time; a negedge process
// checks done timing, result, flags and busy against that queue.
module tb_seq_alu;
    localparam int W = 32;

    localparam logic [3:0] AND_ = 4'd0,  OR_ = 4'd1,  NEG = 4'd2,  NOT_ = 4'd3;
    localparam logic [3:0] ADD = 4'd4,  SUB = 4'd5,  MUL = 4'd6,  DIV = 4'd7;
    localparam logic [3:0] SHR = 4'd8,  SHRA = 4'd9, SHL = 4'd10, ROR = 4'd11;
    localparam logic [3:0] ROL = 4'd12, INCPC = 4'd13, BRANCH = 4'd14, BAD = 4'd15;

    typedef struct {
        logic [63:0] c;
        logic        dz;
        logic        ill;
        int          s;      // cycle from which busy must read 1 (multi-cycle ops)
        int          e;      // cycle at which done must be seen
        bit          multi;
    } exp_t;

    logic clk = 1'b0;
    logic clear;
    int   nvec = 0;
    int   nerr = 0;
    int   cyc  = 0;
    bit   chk_en = 1'b0;
    exp_t q[$];

    always #5 clk = ~clk;

    seq_alu_if #(.WIDTH(W), .OPW(4)) bus ();

    seq_alu #(.WIDTH(W), .OPW(4)) dut (
        .clock (clk),
        .clear (clear),
        .bus   (bus)
    );

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: actual=%h required=%h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic exp_t model(input logic [3:0] op, input logic [31:0] a,
                                   input logic [31:0] b, input int now);
        exp_t e;
        longint signed sa, sb, pr, qq, rr;
        logic [63:0] p64, q64, r64;
        logic [31:0] r;
        int amt, lat;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        e.c = '0; e.dz = 1'b0; e.ill = 1'b0;
        lat = 1;
        amt = int'(b[4:0]);
        r = '0;
        case (op)
            AND_:   r = a & b;
            OR_:    r = a | b;
            NEG:    r = -a;
            NOT_:   r = ~a;
            ADD:    r = a + b;
            SUB:    r = a - b;
            MUL: begin
                pr = sa * sb;
                p64 = pr;
                e.c = p64;
                lat = W/2 + 1;
            end
            DIV: begin
                if (b == 32'h0) begin
                    e.c  = {a, 32'hFFFF_FFFF};
                    e.dz = 1'b1;
                end else begin
                    qq = sa / sb;
                    rr = sa % sb;
                    q64 = qq;
                    r64 = rr;
                    e.c = {r64[31:0], q64[31:0]};
                    lat = W + 2;
                end
            end
            SHR:    r = a >> amt;
            SHRA:   r = $signed(a) >>> amt;
            SHL:    r = a << amt;
            ROR: begin
                r = a;
                repeat (amt) r = {r[0], r[31:1]};
            end
            ROL: begin
                r = a;
                repeat (amt) r = {r[30:0], r[31]};
            end
            INCPC:  r = b + 32'd1;
            BRANCH: r = a + b;
            default: e.ill = 1'b1;
        endcase
        if (op != MUL && op != DIV) e.c = {32'h0, r};
        e.s = now + 1;
        e.e = now + lat;
        e.multi = (lat > 1);
        return e;
    endfunction

    // Compare process: every negedge while checking is enabled.
    always @(negedge clk) begin
        exp_t e;
        logic eb;
        if (chk_en) begin
            if (bus.done) begin
                if (q.size() == 0) begin
                    chk("spurious_done", {63'b0, bus.done}, 64'd0);
                end else begin
                    e = q.pop_front();
                    chk("done_cycle", 64'(cyc), 64'(e.e));
                    chk("result_c", bus.c, e.c);
                    chk("div_zero", {63'b0, bus.div_zero}, {63'b0, e.dz});
                    chk("illegal", {63'b0, bus.illegal}, {63'b0, e.ill});
                end
            end else if (q.size() > 0 && cyc >= q[0].e) begin
                chk("done_missing", {63'b0, bus.done}, 64'd1);
                void'(q.pop_front());
            end
            eb = (q.size() > 0) && q[0].multi && (cyc >= q[0].s) && (cyc < q[0].e);
            chk("busy", {63'b0, bus.busy}, {63'b0, eb});
        end
    end

    task automatic drive(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        bus.start = 1'b1;
        bus.op = op;
        bus.a = a;
        bus.b = b;
    endtask

    task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        drive(op, a, b);
        q.push_back(model(op, a, b, cyc));
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    // start pulse expected to be ignored because an op is in flight
    task automatic pulse(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        drive(op, a, b);
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic wait_done();
        int k = 0;
        while (!bus.done && k < 60) begin
            @(negedge clk);
            k++;
        end
        chk("done_seen", {63'b0, bus.done}, 64'd1);
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 9))
            0: return 32'h8000_0000;
            1: return 32'hFFFF_FFFF;
            2: return 32'h0;
            3: return 32'h7FFF_FFFF;
            4: return 32'($urandom_range(0, 40));
            default: return 32'($urandom);
        endcase
    endfunction

    initial begin
        logic [3:0]  rop;
        logic [31:0] ra, rb;
        exp_t tmp;
        bus.start = 1'b0;
        bus.op = '0;
        bus.a = '0;
        bus.b = '0;
        clear = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_busy", {63'b0, bus.busy}, 64'd0);
        chk("rst_done", {63'b0, bus.done}, 64'd0);
        chk("rst_c", bus.c, 64'd0);
        chk("rst_div_zero", {63'b0, bus.div_zero}, 64'd0);
        chk("rst_illegal", {63'b0, bus.illegal}, 64'd0);
        clear = 1'b1;
        chk_en = 1'b1;

        issue(ADD, 32'd7, 32'd5);                 wait_done();
        chk("add_lit", bus.c, 64'h0000_0000_0000_000C);
        issue(MUL, 32'hFFFF_FFFD, 32'd7);         wait_done();
        chk("mul_lit", bus.c, 64'hFFFF_FFFF_FFFF_FFEB);
        issue(MUL, 32'h8000_0000, 32'h8000_0000); wait_done();
        chk("mul_min_lit", bus.c, 64'h4000_0000_0000_0000);
        issue(DIV, 32'hFFFF_FFEF, 32'd5);         wait_done();
        chk("div_lit", bus.c, 64'hFFFF_FFFE_FFFF_FFFD);
        issue(DIV, 32'd9, 32'd0);                 wait_done();
        chk("div0_lit", bus.c, 64'h0000_0009_FFFF_FFFF);
        chk("div0_flag", {63'b0, bus.div_zero}, 64'd1);
        issue(ADD, 32'd1, 32'd2);                 wait_done();
        chk("div0_cleared", {63'b0, bus.div_zero}, 64'd0);
        issue(ROR, 32'h8000_0001, 32'h0000_0021); wait_done();
        chk("ror_lit", bus.c, 64'h0000_0000_C000_0000);
        issue(BAD, 32'h1234_5678, 32'h9);         wait_done();
        chk("bad_c", bus.c, 64'd0);
        chk("bad_flag", {63'b0, bus.illegal}, 64'd1);
        issue(DIV, 32'h8000_0000, 32'hFFFF_FFFF); wait_done();
        chk("div_min_lit", bus.c, 64'h0000_0000_8000_0000);
        issue(SHL, 32'h0000_1234, 32'h0000_0020); wait_done();
        chk("shamt0_lit", bus.c, 64'h0000_0000_0000_1234);

        // back-to-back: reissue while done is high
        @(negedge clk);
        drive(ADD, 32'd10, 32'd20);
        q.push_back(model(ADD, 32'd10, 32'd20, cyc));
        @(negedge clk);
        chk("b2b_first_done", {63'b0, bus.done}, 64'd1);
        drive(SUB, 32'd3, 32'd5);
        q.push_back(model(SUB, 32'd3, 32'd5, cyc));
        @(negedge clk);
        bus.start = 1'b0;
        chk("b2b_second_done", {63'b0, bus.done}, 64'd1);
        chk("b2b_lit", bus.c, 64'h0000_0000_FFFF_FFFE);

        // start while busy is ignored
        issue(MUL, 32'hFFFF_FFFD, 32'd7);
        repeat (3) @(negedge clk);
        pulse(ADD, 32'd1, 32'd1);
        wait_done();
        chk("ignored_start_lit", bus.c, 64'hFFFF_FFFF_FFFF_FFEB);

        // reset aborts an in-flight MUL
        issue(MUL, 32'hFFFF_FFFD, 32'd7);
        repeat (3) @(negedge clk);
        chk_en = 1'b0;
        clear = 1'b0;
        @(negedge clk);
        clear = 1'b1;
        q.delete();
        chk("abort_busy", {63'b0, bus.busy}, 64'd0);
        chk("abort_c", bus.c, 64'd0);
        chk("abort_done", {63'b0, bus.done}, 64'd0);
        chk_en = 1'b1;
        repeat (20) @(negedge clk);
        issue(ADD, 32'd2, 32'd3);                 wait_done();
        chk("after_abort_lit", bus.c, 64'h0000_0000_0000_0005);

        // reset wins over start in the same cycle
        @(negedge clk);
        chk_en = 1'b0;
        clear = 1'b0;
        drive(ADD, 32'd1, 32'd1);
        @(negedge clk);
        clear = 1'b1;
        bus.start = 1'b0;
        chk("rst_start_done", {63'b0, bus.done}, 64'd0);
        chk("rst_start_c", bus.c, 64'd0);
        chk("rst_start_busy", {63'b0, bus.busy}, 64'd0);
        chk_en = 1'b1;

        for (int i = 0; i < 250; i++) begin
            rop = 4'($urandom_range(0, 15));
            ra = pick();
            rb = pick();
            issue(rop, ra, rb);
            tmp = model(rop, ra, rb, 0);
            if (tmp.multi && $urandom_range(0, 3) == 0) begin
                repeat ($urandom_range(0, 6)) @(negedge clk);
                pulse(4'($urandom_range(0, 15)), pick(), pick());
            end
            wait_done();
        end

        repeat (3) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog expired");
    end

endmodule
